// File: rtl/ddr3_app_arbiter_if.sv
// Handshake bundle between the capture/readback requesters, the arbiter and
// the MIG native app interface. The arbiter connects through the slave
// modport. The requesters and the MIG model connect through the master
// modport.
interface ddr3_app_arbiter_if #(
   parameter int pDATA_WIDTH = 32,
   parameter int pADDR_WIDTH = 30
) ();

   // write requester (capture engine)
   logic                       wr_req;
   logic [pADDR_WIDTH-1:0]     wr_addr;
   logic [2*pDATA_WIDTH-1:0]   wr_data;
   logic                       wr_ack;

   // read requester (USB readback)
   logic                       rd_req;
   logic [pADDR_WIDTH-1:0]     rd_addr;
   logic                       rd_ack;
   logic [pDATA_WIDTH-1:0]     rd_data;
   logic                       rd_data_valid;
   logic                       rd_data_last;

   // MIG app command / write-data side
   logic [pADDR_WIDTH-1:0]     app_addr;
   logic [2:0]                 app_cmd;
   logic                       app_en;
   logic                       app_wdf_wren;
   logic                       app_wdf_end;
   logic [pDATA_WIDTH-1:0]     app_wdf_data;
   logic                       app_rdy;
   logic                       app_wdf_rdy;

   // MIG app read-return side
   logic [pDATA_WIDTH-1:0]     app_rd_data;
   logic                       app_rd_data_valid;
   logic                       app_rd_data_end;

   // arbiter view
   modport slave (
      input  wr_req, wr_addr, wr_data,
      input  rd_req, rd_addr,
      input  app_rdy, app_wdf_rdy,
      input  app_rd_data, app_rd_data_valid, app_rd_data_end,
      output wr_ack, rd_ack, rd_data, rd_data_valid, rd_data_last,
      output app_addr, app_cmd, app_en, app_wdf_wren, app_wdf_end, app_wdf_data
   );

   // requesters + MIG view
   modport master (
      output wr_req, wr_addr, wr_data,
      output rd_req, rd_addr,
      output app_rdy, app_wdf_rdy,
      output app_rd_data, app_rd_data_valid, app_rd_data_end,
      input  wr_ack, rd_ack, rd_data, rd_data_valid, rd_data_last,
      input  app_addr, app_cmd, app_en, app_wdf_wren, app_wdf_end, app_wdf_data
   );

endinterface

// File: rtl/ddr3_app_arbiter.sv
// Two-port arbiter in front of the DDR3 MIG native app interface.
// The write port is fed by the capture engine. The read port is fed by the
// USB readback logic.
// Arbitration is sticky: the port granted last keeps priority. After
// pMAX_BURST consecutive grants it yields, but only if the other port is
// waiting.
// A write is one command plus two data beats. A read is one command.
// Outstanding reads are counted so the MIG read queue cannot be overrun.
// Read data is forwarded straight through to the read port.
module ddr3_app_arbiter #(
   parameter int pDATA_WIDTH      = 32,
   parameter int pADDR_WIDTH      = 30,
   parameter int pMAX_BURST       = 16,
   parameter int pMAX_OUTSTANDING = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                init_calib_complete_i,
   input  logic                clear_err_i,
   output logic                rd_pending_o,
   output logic                rd_underflow_o,
   output logic                grant_wr_o,
   output logic                grant_rd_o,
   ddr3_app_arbiter_if.slave   bus
);

   localparam int BW = $clog2(pMAX_BURST + 1);
   localparam int OW = $clog2(pMAX_OUTSTANDING + 1);

   localparam logic [BW-1:0] MAX_BURST_C = BW'(pMAX_BURST);
   localparam logic [OW-1:0] MAX_OUTST_C = OW'(pMAX_OUTSTANDING);

   // Encoding of the last-granted port.
   localparam logic PORT_WR = 1'b0;
   localparam logic PORT_RD = 1'b1;

   typedef enum logic [1:0] {
      S_ARB    = 2'd0,
      S_WR_CMD = 2'd1,
      S_WR_END = 2'd2,
      S_RD_CMD = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [pADDR_WIDTH-1:0]  app_addr_q, app_addr_d;
   logic                    grant_wr_q, grant_wr_d;
   logic                    grant_rd_q, grant_rd_d;
   logic                    last_grant_q, last_grant_d;
   logic [BW-1:0]           burst_cnt_q, burst_cnt_d;
   logic [OW-1:0]           outstanding_q, outstanding_d;
   logic                    rd_underflow_q, rd_underflow_d;

   logic                    eligible_wr;
   logic                    eligible_rd;
   logic                    pick_rd;
   logic                    wr_ack;
   logic                    rd_ack;
   logic                    data_end;

   // Handshake completions. Both are decoded from state and the MIG ready
   // signals, so the requester sees the ack in the same cycle the MIG
   // accepts the transfer.
   assign wr_ack   = (state_q == S_WR_END) && bus.app_wdf_rdy;
   assign rd_ack   = (state_q == S_RD_CMD) && bus.app_rdy;
   assign data_end = bus.app_rd_data_valid && bus.app_rd_data_end;

   assign eligible_wr = bus.wr_req;
   assign eligible_rd = bus.rd_req && (outstanding_q < MAX_OUTST_C);

   // Arbitration and transaction sequencing: next state, grant and burst
   // bookkeeping.
   always_comb begin
      state_d      = state_q;
      app_addr_d   = app_addr_q;
      grant_wr_d   = grant_wr_q;
      grant_rd_d   = grant_rd_q;
      last_grant_d = last_grant_q;
      burst_cnt_d  = burst_cnt_q;
      pick_rd      = 1'b0;

      case (state_q)
         S_ARB: begin
            if (init_calib_complete_i && (eligible_wr || eligible_rd)) begin
               // When both ports are eligible, the previous owner keeps
               // priority until its burst allowance is used up.
               if (eligible_wr && eligible_rd) begin
                  pick_rd = (burst_cnt_q < MAX_BURST_C) ? last_grant_q : ~last_grant_q;
               end else begin
                  pick_rd = eligible_rd;
               end

               app_addr_d = pick_rd ? bus.rd_addr : bus.wr_addr;
               grant_wr_d = ~pick_rd;
               grant_rd_d = pick_rd;
               state_d    = pick_rd ? S_RD_CMD : S_WR_CMD;

               // The burst counter saturates at the limit. It restarts at 1
               // whenever ownership moves to the other port.
               if (pick_rd == last_grant_q) begin
                  burst_cnt_d = (burst_cnt_q < MAX_BURST_C) ? burst_cnt_q + BW'(1) : burst_cnt_q;
               end else begin
                  burst_cnt_d  = BW'(1);
                  last_grant_d = pick_rd;
               end
            end
         end

         S_WR_CMD: begin
            // The command and beat 0 must be taken together, because both
            // strobes are raised in this state.
            if (bus.app_rdy && bus.app_wdf_rdy) begin
               state_d = S_WR_END;
            end
         end

         S_WR_END: begin
            // Once beat 0 has gone, the write must finish, so the arbiter
            // waits here as long as the MIG requires.
            if (bus.app_wdf_rdy) begin
               state_d    = S_ARB;
               grant_wr_d = 1'b0;
            end
         end

         S_RD_CMD: begin
            if (bus.app_rdy) begin
               state_d    = S_ARB;
               grant_rd_d = 1'b0;
            end
         end

         default: begin
            state_d = S_ARB;
         end
      endcase
   end

   // Outstanding-read accounting. A simultaneous issue and return leaves the
   // count unchanged.
   // A return that arrives while the count is zero is flagged and otherwise
   // ignored.
   // When clear_err and a new underflow happen in the same cycle, the flag
   // stays set.
   always_comb begin
      outstanding_d  = outstanding_q;
      rd_underflow_d = rd_underflow_q;

      if (clear_err_i) begin
         rd_underflow_d = 1'b0;
      end

      if (rd_ack && !data_end) begin
         outstanding_d = outstanding_q + OW'(1);
      end else if (!rd_ack && data_end) begin
         if (outstanding_q == '0) begin
            rd_underflow_d = 1'b1;
         end else begin
            outstanding_d = outstanding_q - OW'(1);
         end
      end
   end

   // State and bookkeeping registers. Reset takes effect immediately and
   // abandons any transaction in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= S_ARB;
         app_addr_q     <= '0;
         grant_wr_q     <= 1'b0;
         grant_rd_q     <= 1'b0;
         last_grant_q   <= PORT_WR;
         burst_cnt_q    <= '0;
         outstanding_q  <= '0;
         rd_underflow_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         app_addr_q     <= app_addr_d;
         grant_wr_q     <= grant_wr_d;
         grant_rd_q     <= grant_rd_d;
         last_grant_q   <= last_grant_d;
         burst_cnt_q    <= burst_cnt_d;
         outstanding_q  <= outstanding_d;
         rd_underflow_q <= rd_underflow_d;
      end
   end

   // MIG strobes are decoded from state so that they drop to zero as soon
   // as reset is asserted.
   assign bus.app_en       = (state_q == S_WR_CMD) || (state_q == S_RD_CMD);
   assign bus.app_wdf_wren = (state_q == S_WR_CMD) || (state_q == S_WR_END);
   assign bus.app_wdf_end  = (state_q == S_WR_END);
   assign bus.app_wdf_data = (state_q == S_WR_CMD) ? bus.wr_data[pDATA_WIDTH-1:0] :
                             (state_q == S_WR_END) ? bus.wr_data[2*pDATA_WIDTH-1:pDATA_WIDTH] :
                             '0;
   // Read when the read port owns the bus. Otherwise (a write, or idle) the
   // encoding is 000.
   assign bus.app_cmd      = {2'b00, grant_rd_q};
   assign bus.app_addr     = app_addr_q;

   assign bus.wr_ack        = wr_ack;
   assign bus.rd_ack        = rd_ack;
   // The MIG returns reads in order, so read data bypasses the arbiter
   // state.
   assign bus.rd_data       = bus.app_rd_data;
   assign bus.rd_data_valid = bus.app_rd_data_valid;
   assign bus.rd_data_last  = data_end;

   assign rd_pending_o   = (outstanding_q != '0);
   assign rd_underflow_o = rd_underflow_q;
   assign grant_wr_o     = grant_wr_q;
   assign grant_rd_o     = grant_rd_q;

endmodule

// File: tb/tb_ddr3_app_arbiter.sv
// Directed bench for ddr3_app_arbiter: single write, sticky burst
// arbitration, outstanding-read limit, MIG back-pressure, underflow flag and
// asynchronous reset.
// Inputs change on the falling edge. Outputs are checked 1 ns later, well
// away from the rising edge.
module tb_ddr3_app_arbiter;

   localparam int DW   = 32;
   localparam int AW   = 30;
   localparam int MAXB = 4;
   localparam int MAXO = 8;

   logic clk        = 1'b0;
   logic reset_n    = 1'b0;
   logic init_calib = 1'b0;
   logic clear_err  = 1'b0;
   logic rd_pending, rd_underflow, grant_wr, grant_rd;

   int n_tests = 0;
   int n_fail  = 0;

   int       cnt;
   int       k;
   logic     acc;
   byte      got_c;
   string    exp_seq;
   int       exp_burst [12];
   logic [AW-1:0] addr_snap;

   ddr3_app_arbiter_if #(.pDATA_WIDTH(DW), .pADDR_WIDTH(AW)) bus ();

   ddr3_app_arbiter #(
      .pDATA_WIDTH      (DW),
      .pADDR_WIDTH      (AW),
      .pMAX_BURST       (MAXB),
      .pMAX_OUTSTANDING (MAXO)
   ) dut (
      .clk                   (clk),
      .reset_n               (reset_n),
      .init_calib_complete_i (init_calib),
      .clear_err_i           (clear_err),
      .rd_pending_o          (rd_pending),
      .rd_underflow_o        (rd_underflow),
      .grant_wr_o            (grant_wr),
      .grant_rd_o            (grant_rd),
      .bus                   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.wr_req            = 1'b0;
      bus.wr_addr           = '0;
      bus.wr_data           = '0;
      bus.rd_req            = 1'b0;
      bus.rd_addr           = '0;
      bus.app_rd_data       = '0;
      bus.app_rd_data_valid = 1'b0;
      bus.app_rd_data_end   = 1'b0;
      bus.app_rdy           = 1'b1;
      bus.app_wdf_rdy       = 1'b1;
      clear_err             = 1'b0;
   endtask

   // Leaves the bench on a falling edge with reset just released.
   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      idle_inputs();
      init_calib = 1'b1;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   // Timeout guard so that a hung DUT still reaches a verdict.
   initial begin
      #200000;
      $display("FAIL global_timeout: got simulation still running, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      idle_inputs();
      init_calib = 1'b1;

      // ---------------- reset state ----------------
      repeat (2) @(negedge clk);
      #1;
      check("rst_strobes", {bus.app_en, bus.app_wdf_wren, bus.app_wdf_end, bus.wr_ack, bus.rd_ack}, 5'b0);
      check("rst_status", {grant_wr, grant_rd, rd_pending, rd_underflow}, 4'b0);
      check("rst_addr_cmd", {bus.app_addr, bus.app_cmd}, '0);

      // ---------------- test 1: single write ----------------
      do_reset();
      bus.wr_req  = 1'b1;
      bus.wr_addr = 30'h100;
      bus.wr_data = 64'hBBBBBBBB_AAAAAAAA;
      #1 check("t1_arb_en", bus.app_en, 1'b0);
      @(negedge clk); #1;
      check("t1_cmd_strobes", {bus.app_en, bus.app_wdf_wren, bus.app_wdf_end, bus.wr_ack}, 4'b1100);
      check("t1_beat0", bus.app_wdf_data, 32'hAAAAAAAA);
      check("t1_cmd", bus.app_cmd, 3'b000);
      check("t1_grant_wr", {grant_wr, grant_rd}, 2'b10);
      check("t1_addr", bus.app_addr, 30'h100);
      @(negedge clk); #1;
      check("t1_end_strobes", {bus.app_en, bus.app_wdf_wren, bus.app_wdf_end, bus.wr_ack}, 4'b0111);
      check("t1_beat1", bus.app_wdf_data, 32'hBBBBBBBB);
      bus.wr_req = 1'b0;
      $display("[TB] write addr=0x%0h data=0x%0h acked", bus.wr_addr, bus.wr_data);
      @(negedge clk); #1;
      check("t1_idle", {bus.app_en, bus.app_wdf_wren, bus.wr_ack, grant_wr}, 4'b0);

      // ---------------- test 2: sticky burst arbitration ----------------
      do_reset();
      exp_seq   = "WWWWRRRRWWWW";
      exp_burst = '{1, 2, 3, 4, 1, 2, 3, 4, 1, 2, 3, 4};
      bus.wr_req  = 1'b1;
      bus.wr_addr = 30'h1000;
      bus.wr_data = 64'h12345678_9ABCDEF0;
      bus.rd_req  = 1'b1;
      bus.rd_addr = 30'h2000;
      k = 0;
      for (int cyc = 0; cyc < 300 && k < 12; cyc++) begin
         @(negedge clk);
         // Return one read beat per cycle while reads are pending, so the
         // outstanding limit never throttles this test.
         bus.app_rd_data_valid = rd_pending;
         bus.app_rd_data_end   = rd_pending;
         #1;
         if (bus.wr_ack || bus.rd_ack) begin
            got_c = bus.wr_ack ? "W" : "R";
            check($sformatf("t2_owner%0d", k), got_c, exp_seq[k]);
            check($sformatf("t2_burst%0d", k), 64'(dut.burst_cnt_q), 64'(exp_burst[k]));
            $display("[TB] burst grant %0d: %s burst_cnt=%0d", k, (bus.wr_ack ? "WR" : "RD"), dut.burst_cnt_q);
            k++;
         end
      end
      check("t2_grant_count", k, 12);
      bus.wr_req = 1'b0;
      bus.rd_req = 1'b0;
      @(negedge clk);
      bus.app_rd_data_valid = 1'b0;
      bus.app_rd_data_end   = 1'b0;

      // ---------------- test 3: outstanding-read limit + calibration gate ----------------
      do_reset();
      init_calib  = 1'b0;
      bus.rd_req  = 1'b1;
      bus.rd_addr = 30'h200;
      acc = 1'b0;
      repeat (4) begin
         @(negedge clk); #1;
         acc |= bus.app_en;
      end
      check("t3_no_grant_uncal", acc, 1'b0);
      init_calib = 1'b1;
      cnt = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk); #1;
         if (bus.rd_ack) cnt++;
      end
      $display("[TB] reads accepted without data return: %0d", cnt);
      check("t3_acks_at_limit", cnt, 8);
      check("t3_outstanding", 64'(dut.outstanding_q), 64'd8);
      check("t3_stalled", {rd_pending, grant_rd, bus.app_en}, 3'b100);
      @(negedge clk);
      bus.app_rd_data       = 32'h0BADF00D;
      bus.app_rd_data_valid = 1'b1;
      bus.app_rd_data_end   = 1'b0;
      #1;
      check("t3_mid_beat", {bus.rd_data_valid, bus.rd_data_last}, 2'b10);
      @(negedge clk);
      bus.app_rd_data     = 32'hDEADBEEF;
      bus.app_rd_data_end = 1'b1;
      #1;
      check("t3_rd_data", bus.rd_data, 32'hDEADBEEF);
      check("t3_last_beat", {bus.rd_data_valid, bus.rd_data_last}, 2'b11);
      @(negedge clk);
      bus.app_rd_data_valid = 1'b0;
      bus.app_rd_data_end   = 1'b0;
      cnt = 0;
      for (int c = 0; c < 10; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         if (bus.rd_ack) cnt++;
      end
      $display("[TB] reads accepted after one return: %0d", cnt);
      check("t3_ack_after_return", cnt, 1);
      bus.rd_req = 1'b0;

      // ---------------- test 4: MIG back-pressure ----------------
      do_reset();
      bus.app_rdy     = 1'b0;
      bus.app_wdf_rdy = 1'b1;
      bus.wr_req      = 1'b1;
      bus.wr_addr     = 30'h3ABC;
      bus.wr_data     = 64'h22222222_11111111;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk); #1;
         check($sformatf("t4_cmd_hold%0d", c), {bus.app_en, bus.app_wdf_wren, bus.app_wdf_end, bus.wr_ack}, 4'b1100);
         check($sformatf("t4_cmd_addr%0d", c), bus.app_addr, 30'h3ABC);
      end
      bus.app_rdy = 1'b1;
      @(negedge clk);
      bus.app_wdf_rdy = 1'b0;
      for (int c = 0; c < 3; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         check($sformatf("t4_end_hold%0d", c), {bus.app_en, bus.app_wdf_wren, bus.app_wdf_end, bus.wr_ack}, 4'b0110);
         check($sformatf("t4_end_addr%0d", c), bus.app_addr, 30'h3ABC);
      end
      bus.app_wdf_rdy = 1'b1;
      #1;
      check("t4_ack", bus.wr_ack, 1'b1);
      check("t4_beat1", bus.app_wdf_data, 32'h22222222);
      bus.wr_req = 1'b0;
      $display("[TB] write addr=0x%0h acked after back-pressure", bus.wr_addr);
      acc = 1'b0;
      repeat (5) begin
         @(negedge clk); #1;
         acc |= bus.wr_ack | bus.app_en;
      end
      check("t4_single_ack", acc, 1'b0);

      // ---------------- test 5: counter corner cases and underflow ----------------
      do_reset();
      bus.rd_req  = 1'b1;
      bus.rd_addr = 30'h55;
      acc = 1'b0;
      for (int c = 0; c < 20 && !acc; c++) begin
         @(negedge clk); #1;
         acc = bus.rd_ack;
      end
      check("t5_rd1_ack", acc, 1'b1);
      check("t5_rd_cmd", {bus.app_cmd, grant_rd}, {3'b001, 1'b1});
      check("t5_rd_addr", bus.app_addr, 30'h55);
      bus.rd_req = 1'b0;
      $display("[TB] read addr=0x55 acked");
      @(negedge clk);
      bus.rd_req  = 1'b1;
      bus.rd_addr = 30'h56;
      acc = 1'b0;
      for (int c = 0; c < 20 && !acc; c++) begin
         @(negedge clk); #1;
         acc = bus.rd_ack;
      end
      check("t5_rd2_ack", acc, 1'b1);
      // A data-end beat arrives in the same cycle as the second ack.
      bus.rd_req            = 1'b0;
      bus.app_rd_data_valid = 1'b1;
      bus.app_rd_data_end   = 1'b1;
      $display("[TB] read addr=0x56 acked with concurrent data end");
      @(negedge clk);
      bus.app_rd_data_valid = 1'b0;
      bus.app_rd_data_end   = 1'b0;
      #1;
      check("t5_same_cycle", 64'(dut.outstanding_q), 64'd1);
      bus.app_rd_data_valid = 1'b1;
      bus.app_rd_data_end   = 1'b1;
      @(negedge clk);
      bus.app_rd_data_valid = 1'b0;
      bus.app_rd_data_end   = 1'b0;
      #1;
      check("t5_drained", {rd_pending, rd_underflow}, 2'b00);
      bus.app_rd_data_valid = 1'b1;
      bus.app_rd_data_end   = 1'b1;
      @(negedge clk);
      bus.app_rd_data_valid = 1'b0;
      bus.app_rd_data_end   = 1'b0;
      #1;
      check("t5_underflow_set", {rd_pending, rd_underflow}, 2'b01);
      check("t5_count_held", 64'(dut.outstanding_q), 64'd0);
      clear_err             = 1'b1;
      bus.app_rd_data_valid = 1'b1;
      bus.app_rd_data_end   = 1'b1;
      @(negedge clk);
      bus.app_rd_data_valid = 1'b0;
      bus.app_rd_data_end   = 1'b0;
      #1;
      check("t5_set_beats_clear", rd_underflow, 1'b1);
      @(negedge clk);
      clear_err = 1'b0;
      #1;
      check("t5_cleared", rd_underflow, 1'b0);

      // ---------------- test 6: asynchronous reset mid-write ----------------
      do_reset();
      bus.wr_req  = 1'b1;
      bus.wr_addr = 30'h444;
      bus.wr_data = 64'h44444444_33333333;
      @(negedge clk);
      @(negedge clk); #1;
      check("t6_in_wr_end", bus.app_wdf_end, 1'b1);
      #1;
      reset_n     = 1'b0;
      bus.wr_req  = 1'b0;
      bus.rd_req  = 1'b1;
      bus.rd_addr = 30'h777;
      #1;
      check("t6_async_strobes", {bus.app_en, bus.app_wdf_wren, bus.app_wdf_end, bus.wr_ack, bus.rd_ack}, 5'b0);
      check("t6_async_status", {grant_wr, grant_rd, bus.app_cmd}, 5'b0);
      check("t6_async_data", {bus.app_addr, bus.app_wdf_data}, '0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check("t6_release_idle", {bus.app_en, bus.app_wdf_wren}, 2'b00);
      @(negedge clk); #1;
      check("t6_rd_granted", {grant_rd, bus.app_en, bus.rd_ack, bus.app_cmd}, {3'b111, 3'b001});
      check("t6_rd_addr", bus.app_addr, 30'h777);
      bus.rd_req = 1'b0;
      $display("[TB] read addr=0x777 acked after reset");
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
